// File: rtl/rgb_pkg.sv
// rgb_pkg: shared colour/sync defaults for the VGA pixel output stage
package rgb_pkg;
    localparam int COLOR_W = 8;
    localparam logic [COLOR_W-1:0] BLACK = '0;
    localparam logic [COLOR_W-1:0] TRANSP_KEY = 8'hE3;
    localparam logic SYNC_IDLE = 1'b1;
endpackage

// File: rtl/frame_blink_timer.sv
// frame_blink_timer: counts vsync falling edges and toggles blink_phase_o every BLINK_FRAMES frames
// Ports: clk, reset (sync, active-high), vsync_i (raw vsync), blink_phase_o (1 = blinking layers shown)
module frame_blink_timer
    import rgb_pkg::*;
#(
    parameter int   BLINK_FRAMES = 30,
    parameter logic SYNC_IDLE    = rgb_pkg::SYNC_IDLE
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync_i,
    output logic blink_phase_o
);
    localparam int CNT_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

    logic             vsync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             tick, wrap;

    always_comb begin
        tick    = vsync_q & ~vsync_i;
        wrap    = tick && (cnt_q == LAST);
        cnt_d   = tick ? (wrap ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
        phase_d = phase_q ^ wrap;
    end

    // Edge detector loads the idle level so leaving reset never fakes a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q <= SYNC_IDLE;
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            vsync_q <= vsync_i;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_phase_o = phase_q;
endmodule

// File: rtl/rgb_layer_mux.sv
// rgb_layer_mux: two-stage priority merge of overlay layers with transparency, blink and blanking
// Ports: clk, reset (sync, active-high); video_on/hsync_in/vsync_in from the sync generator;
//        layer_color/layer_en/layer_blink per layer, bg_color fallback;
//        rgb, hsync_out, vsync_out, video_on_out all delayed by exactly 2 cycles.
module rgb_layer_mux
    import rgb_pkg::*;
#(
    parameter int                    COLOR_W      = rgb_pkg::COLOR_W,
    parameter int                    NUM_LAYERS   = 4,
    parameter logic [COLOR_W-1:0]    TRANSP_KEY   = rgb_pkg::TRANSP_KEY,
    parameter int                    BLINK_FRAMES = 30,
    parameter logic                  SYNC_IDLE    = rgb_pkg::SYNC_IDLE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          video_on,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS-1:0]         layer_blink,
    input  logic [COLOR_W-1:0]            bg_color,
    output logic [COLOR_W-1:0]            rgb,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic                          video_on_out
);
    logic                          von_q, hs_q, vs_q;
    logic [NUM_LAYERS*COLOR_W-1:0] color_q;
    logic [NUM_LAYERS-1:0]         en_q, blink_q;
    logic [COLOR_W-1:0]            bg_q;
    logic [COLOR_W-1:0]            sel, rgb_d, rgb_q;
    logic                          von2_q, hs2_q, vs2_q;
    logic                          blink_phase;

    frame_blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .SYNC_IDLE    (SYNC_IDLE)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .vsync_i       (vsync_in),
        .blink_phase_o (blink_phase)
    );

    // Walk from the highest index down so the lowest visible index is written last and wins.
    always_comb begin
        sel = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (en_q[i] && color_q[i*COLOR_W +: COLOR_W] != TRANSP_KEY && (!blink_q[i] || blink_phase))
                sel = color_q[i*COLOR_W +: COLOR_W];
        rgb_d = von_q ? sel : COLOR_W'(BLACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            von_q   <= 1'b0;
            hs_q    <= SYNC_IDLE;
            vs_q    <= SYNC_IDLE;
            color_q <= '0;
            en_q    <= '0;
            blink_q <= '0;
            bg_q    <= '0;
            rgb_q   <= COLOR_W'(BLACK);
            von2_q  <= 1'b0;
            hs2_q   <= SYNC_IDLE;
            vs2_q   <= SYNC_IDLE;
        end else begin
            von_q   <= video_on;
            hs_q    <= hsync_in;
            vs_q    <= vsync_in;
            color_q <= layer_color;
            en_q    <= layer_en;
            blink_q <= layer_blink;
            bg_q    <= bg_color;
            rgb_q   <= rgb_d;
            von2_q  <= von_q;
            hs2_q   <= hs_q;
            vs2_q   <= vs_q;
        end
    end

    assign rgb          = rgb_q;
    assign hsync_out    = hs2_q;
    assign vsync_out    = vs2_q;
    assign video_on_out = von2_q;
endmodule

// File: tb/tb_rgb_layer_mux.sv
// tb_rgb_layer_mux: directed table and sequence checks of rgb_layer_mux with BLINK_FRAMES = 2
module tb_rgb_layer_mux;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [31:0] layer_color = '0;
    logic [3:0]  layer_en = '0, layer_blink = '0;
    logic [7:0]  bg_color = '0;
    logic [7:0]  rgb;
    logic        hsync_out, vsync_out, video_on_out;

    int checks = 0, failures = 0;

    typedef struct {
        logic        v, h, s;
        logic [31:0] col;
        logic [3:0]  en, bl;
        logic [7:0]  bg, exp;
    } tv_t;

    typedef struct {
        logic       valid;
        logic [7:0] rgb;
        logic       v, h, s;
    } exp_t;

    localparam exp_t RST = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1};

    exp_t e1 = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    exp_t e2 = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tv_t  tv[11];

    rgb_layer_mux #(
        .COLOR_W      (8),
        .NUM_LAYERS   (4),
        .TRANSP_KEY   (8'hE3),
        .BLINK_FRAMES (2),
        .SYNC_IDLE    (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .video_on     (video_on),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .layer_color  (layer_color),
        .layer_en     (layer_en),
        .layer_blink  (layer_blink),
        .bg_color     (bg_color),
        .rgb          (rgb),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .video_on_out (video_on_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // One pixel clock: check the outputs owed from two steps ago, then drive the new inputs.
    task automatic step(input string tag, input logic r, input logic v, input logic h, input logic s,
                        input logic [31:0] col, input logic [3:0] en, input logic [3:0] bl,
                        input logic [7:0] bg, input logic [7:0] exp);
        @(negedge clk);
        if (e1.valid) begin
            chk({tag, " rgb"}, rgb, e1.rgb);
            chk({tag, " video_on_out"}, {7'd0, video_on_out}, {7'd0, e1.v});
            chk({tag, " hsync_out"}, {7'd0, hsync_out}, {7'd0, e1.h});
            chk({tag, " vsync_out"}, {7'd0, vsync_out}, {7'd0, e1.s});
        end
        e1 = e2;
        e2 = '{1'b1, exp, v, h, s};
        if (r) begin
            e1 = RST;
            e2 = RST;
        end
        reset       = r;
        video_on    = v;
        hsync_in    = h;
        vsync_in    = s;
        layer_color = col;
        layer_en    = en;
        layer_blink = bl;
        bg_color    = bg;
    endtask

    logic ph, pv;
    int   cnt;

    initial begin
        tv[0]  = '{1'b1, 1'b1, 1'b1, 32'hAAE01CFF, 4'b0110, 4'b0000, 8'h03, 8'h1C};
        tv[1]  = '{1'b1, 1'b0, 1'b1, 32'hAAE0E3FF, 4'b0110, 4'b0000, 8'h03, 8'hE0};
        tv[2]  = '{1'b1, 1'b0, 1'b1, 32'hAAE0E3FF, 4'b0000, 4'b0000, 8'h03, 8'h03};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 32'hAAE01CFF, 4'b1111, 4'b0000, 8'h03, 8'h00};
        tv[4]  = '{1'b1, 1'b1, 1'b0, 32'h55E3E3E3, 4'b1111, 4'b0000, 8'h03, 8'h55};
        tv[5]  = '{1'b1, 1'b0, 1'b1, 32'hE3E3E3E3, 4'b1111, 4'b0000, 8'h7A, 8'h7A};
        tv[6]  = '{1'b1, 1'b1, 1'b1, 32'h112233E3, 4'b0001, 4'b0000, 8'hE3, 8'hE3};
        tv[7]  = '{1'b1, 1'b1, 1'b1, 32'h11223312, 4'b1111, 4'b0000, 8'h00, 8'h12};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 32'h11226644, 4'b0011, 4'b0001, 8'h00, 8'h44};
        tv[9]  = '{1'b1, 1'b1, 1'b1, 32'hE32266E3, 4'b1001, 4'b0000, 8'h09, 8'h09};
        tv[10] = '{1'b1, 1'b1, 1'b1, 32'h77226644, 4'b1000, 4'b1000, 8'h09, 8'h77};

        // Reset held 3 cycles under random inputs, then a known pixel 2 cycles after release.
        for (int i = 0; i < 3; i++)
            step("reset", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                 4'($urandom), 4'($urandom), 8'($urandom), 8'h00);
        step("reset_exit", 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000005A, 4'b0001, 4'b0000, 8'h00, 8'h5A);

        for (int i = 0; i < 11; i++)
            step($sformatf("vec%0d", i), 1'b0, tv[i].v, tv[i].h, tv[i].s, tv[i].col,
                 tv[i].en, tv[i].bl, tv[i].bg, tv[i].exp);

        for (int i = 0; i < 12; i++) begin
            logic v;
            v = !(i >= 3 && i < 8);
            step($sformatf("blank%0d", i), 1'b0, v, 1'b1, 1'b1, 32'h11223344, 4'b0000,
                 4'b0000, 8'h03, v ? 8'h03 : 8'h00);
        end

        for (int i = 0; i < 15; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            step($sformatf("sync%0d", i), 1'b0, 1'b1, (i % 3) != 0, (i % 5) != 1,
                 $urandom, 4'b0000, 4'b0000, b, b);
        end

        // Blink with 6-cycle frames; a reset lands mid-frame while frame_cnt = 1.
        step("blink_rst", 1'b1, 1'b1, 1'b1, 1'b1, 32'h000000FF, 4'b0001, 4'b0001, 8'h00, 8'h00);
        ph = 1'b1; cnt = 0; pv = 1'b1;
        for (int s = 0; s < 54; s++) begin
            logic r, vs;
            r  = (s == 27);
            vs = (s % 6) != 0;
            if (r) begin
                ph = 1'b1; cnt = 0; pv = 1'b1;
            end else begin
                if (pv && !vs) begin
                    if (cnt == 1) begin
                        cnt = 0;
                        ph  = !ph;
                    end else cnt++;
                end
                pv = vs;
            end
            step($sformatf("blink%0d", s), r, 1'b1, 1'b1, vs, 32'h000000FF, 4'b0001, 4'b0001,
                 8'h00, ph ? 8'hFF : 8'h00);
        end
        step("drain0", 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0, 8'h00, 8'h00);
        step("drain1", 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0, 8'h00, 8'h00);
        step("drain2", 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
